key_click_decoder: RTL and testbench

- Consumer of the debounced single-cycle key pulses produced by the key detect block.
- Groups pulses that arrive within a programmable time window into one click event: single, double, or up to MAX_CLICKS.
- Reports each event as a one-cycle valid strobe plus a click count.
- Sits between the key detect stage and the mode and menu control logic.

---
 rtl/key_click_decoder.sv | 91 +++++++++
 tb/tb_key_click_decoder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// key_click_decoder: groups debounced key pulses arriving within a time window into click events
//   clk          system clock
//   rst          asynchronous reset, active-high
//   key_pulse    one-cycle press pulse from the debounce stage
//   click_valid  one-cycle strobe marking a completed click event
//   click_count  clicks in the event, valid while click_valid=1
//   busy         high while a click sequence is open
//   total_events running event count, present only when KEY_CLICK_TOTAL_EN is defined
module key_click_decoder #(
    parameter int WINDOW_CNT = 5_000_000,
    parameter int TMR_W      = 24,
    parameter int MAX_CLICKS = 3,
    parameter int CNT_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_pulse,
    output logic             click_valid,
    output logic [CNT_W-1:0] click_count,
`ifdef KEY_CLICK_TOTAL_EN
    output logic [15:0]      total_events,
`endif
    output logic             busy
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW_CNT - 1);
    localparam logic [CNT_W:0]   MAX_C    = (CNT_W+1)'(MAX_CLICKS);
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d, ccount_d;
    logic             valid_d;
    logic             last_click;
    // widened by one bit so count+1 cannot wrap before the compare
    assign last_click = ({1'b0, count_q} + 1'b1) == MAX_C;
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        ccount_d = click_count;
        if (state_q == IDLE) begin
            if (key_pulse) begin
                count_d = CNT_W'(1);
                timer_d = '0;
                state_d = WAIT;
            end
        end else if (key_pulse) begin
            // a pulse takes priority over a timeout on the same edge
            if (last_click) begin
                valid_d  = 1'b1;
                ccount_d = MAX_C[CNT_W-1:0];
                count_d  = '0;
                state_d  = IDLE;
            end else begin
                count_d = count_q + 1'b1;
                timer_d = '0;
            end
        end else if (timer_q == WIN_LAST) begin
            valid_d  = 1'b1;
            ccount_d = count_q;
            count_d  = '0;
            timer_d  = '0;
            state_d  = IDLE;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            count_q     <= '0;
            click_valid <= 1'b0;
            click_count <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            click_valid <= valid_d;
            click_count <= ccount_d;
            busy        <= state_d == WAIT;
        end
    end
`ifdef KEY_CLICK_TOTAL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) total_events <= '0;
        else if (valid_d) total_events <= total_events + 1'b1;
    end
`endif
endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: scoreboard bench for key_click_decoder with a 100-cycle window and 3-click limit
module tb_key_click_decoder;
    localparam int W = 100;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_pulse = 1'b0;
    logic       click_valid;
    logic [1:0] click_count;
    logic       busy;
`ifdef KEY_CLICK_TOTAL_EN
    logic [15:0] total_events;
`endif
    typedef struct {int cyc; int cnt;} ev_t;
    ev_t q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;
    int  exp_tot = 0;
    key_click_decoder #(.WINDOW_CNT(W), .TMR_W(8), .MAX_CLICKS(3), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .key_pulse(key_pulse),
        .click_valid(click_valid),
        .click_count(click_count),
`ifdef KEY_CLICK_TOTAL_EN
        .total_events(total_events),
`endif
        .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    // drive one pulse; returns the edge number at which it is sampled
    task automatic press(output int t);
        key_pulse = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        key_pulse = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (!rst && click_valid) begin
            if (q.size() == 0) chk("unexpected_event", 1, 0);
            else begin
                ev_t e;
                e = q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_count", int'(click_count), e.cnt);
                exp_tot++;
`ifdef KEY_CLICK_TOTAL_EN
                chk("total_events", int'(total_events), exp_tot);
`endif
            end
        end
    end
    initial begin
        int t1, t2, t3;
        #1;
        chk("rst_valid", int'(click_valid), 0);
        chk("rst_count", int'(click_count), 0);
        chk("rst_busy", int'(busy), 0);
        idle(3);
        rst = 1'b0;
        idle(2);
        // single click
        press(t1);
        chk("busy_open", int'(busy), 1);
        q.push_back('{t1 + W, 1});
        idle(W + 10);
        chk("busy_closed", int'(busy), 0);
        // double click, 50 cycles apart
        press(t1);
        idle(49);
        press(t2);
        chk("busy_double", int'(busy), 1);
        q.push_back('{t2 + W, 2});
        idle(W + 10);
        // triple click reaches the limit immediately
        press(t1);
        idle(9);
        press(t2);
        idle(9);
        press(t3);
        q.push_back('{t3, 3});
        chk("busy_max_drop", int'(busy), 0);
        idle(W + 10);
        // second pulse lands on the last window cycle
        press(t1);
        idle(W - 1);
        press(t2);
        chk("edge_pulse_gap", t2 - t1, W);
        q.push_back('{t2 + W, 2});
        idle(W + 10);
        // pulse during the strobe cycle opens a new sequence
        press(t1);
        q.push_back('{t1 + W, 1});
        idle(W);
        chk("strobe_now", int'(click_valid), 1);
        press(t2);
        q.push_back('{t2 + W, 1});
        idle(W + 10);
        chk("pending_before_rst", q.size(), 0);
        // reset mid-sequence discards it
        press(t1);
        idle(5);
        press(t2);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(click_valid), 0);
        chk("midrst_count", int'(click_count), 0);
        chk("midrst_busy", int'(busy), 0);
        exp_tot = 0;
`ifdef KEY_CLICK_TOTAL_EN
        chk("midrst_total", int'(total_events), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        idle(W + 10);
        press(t1);
        q.push_back('{t1 + W, 1});
        idle(W + 10);
        press(t1);
        idle(3);
        press(t2);
        q.push_back('{t2 + W, 2});
        idle(W + 10);
        chk("pending_end", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
